// File: rtl/doodlejump_keycode_sched.sv
// Keyboard event scheduler: turns keycode level changes into paired PRESS/RELEASE events in a FWFT FIFO.
// Define KEYSCHED_REPEAT_EN to add typematic REPEAT events while a key stays held.
module doodlejump_keycode_sched #(
  parameter int KC_W          = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [KC_W-1:0]               keycode_in,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [KC_W-1:0]               ev_code,
  output logic [1:0]                    ev_type,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic [KC_W-1:0]               held_code,
  output logic                          overflow,
  input  logic                          clr_overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
    $error("doodlejump_keycode_sched: illegal parameter value");
  end

  typedef enum logic [1:0] {EV_PRESS = 2'b00, EV_RELEASE = 2'b01, EV_REPEAT = 2'b10} ev_type_e;
  typedef struct packed {
    logic [KC_W-1:0] code;
    logic [1:0]      typ;
  } ev_t;
  typedef enum logic [1:0] {S_IDLE, S_HELD, S_REL, S_PRESS} state_e;

  state_e          state, state_nxt;
  logic [KC_W-1:0] kc_s, pend, pend_nxt, held_nxt;
  logic            push;
  ev_t             push_ev;

`ifdef KEYSCHED_REPEAT_EN
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W   = $clog2(RC_MAX);
  logic [RC_W-1:0] rcnt, rcnt_nxt;
  logic            first_done, first_nxt;
`endif

  // Sequencer: at most one push per cycle; a change always beats a due repeat.
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    held_nxt  = held_code;
    push      = 1'b0;
    push_ev   = '0;
`ifdef KEYSCHED_REPEAT_EN
    rcnt_nxt  = rcnt;
    first_nxt = first_done;
`endif
    case (state)
      S_IDLE, S_HELD: begin
        if (kc_s != held_code) begin
          pend_nxt  = kc_s;
          state_nxt = (held_code != '0) ? S_REL : S_PRESS;
        end
`ifdef KEYSCHED_REPEAT_EN
        else if (state == S_HELD) begin
          if (!first_done && rcnt == RC_W'(REPEAT_DELAY - 1)) begin
            push      = 1'b1;
            push_ev   = '{code: held_code, typ: EV_REPEAT};
            rcnt_nxt  = '0;
            first_nxt = 1'b1;
          end else if (first_done && rcnt == RC_W'(REPEAT_PERIOD - 1)) begin
            push      = 1'b1;
            push_ev   = '{code: held_code, typ: EV_REPEAT};
            rcnt_nxt  = '0;
          end else begin
            rcnt_nxt  = rcnt + 1'b1;
          end
        end
`endif
      end
      S_REL: begin
        push      = 1'b1;
        push_ev   = '{code: held_code, typ: EV_RELEASE};
        held_nxt  = '0;
        state_nxt = (pend != '0) ? S_PRESS : S_IDLE;
      end
      default: begin
        push      = 1'b1;
        push_ev   = '{code: pend, typ: EV_PRESS};
        held_nxt  = pend;
        state_nxt = S_HELD;
`ifdef KEYSCHED_REPEAT_EN
        rcnt_nxt  = '0;
        first_nxt = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      kc_s      <= '0;
      pend      <= '0;
      held_code <= '0;
    end else begin
      state     <= state_nxt;
      kc_s      <= keycode_in;
      pend      <= pend_nxt;
      held_code <= held_nxt;
    end
  end

`ifdef KEYSCHED_REPEAT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt       <= '0;
      first_done <= 1'b0;
    end else begin
      rcnt       <= rcnt_nxt;
      first_done <= first_nxt;
    end
  end
`endif

  // Event FIFO, first-word-fall-through; a push into a full FIFO survives only if the head pops.
  ev_t [FIFO_DEPTH-1:0] mem;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 pop, full, push_ok, drop;

  assign ev_valid = (ev_count != '0);
  assign pop      = ev_valid & ev_ready;
  assign full     = (ev_count == CNT_W'(FIFO_DEPTH));
  assign push_ok  = push & (~full | pop);
  assign drop     = push & full & ~pop;
  assign ev_code  = mem[rd_ptr].code;
  assign ev_type  = mem[rd_ptr].typ;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ev_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_ev;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   ev_count <= ev_count + 1'b1;
        2'b01:   ev_count <= ev_count - 1'b1;
        default: ev_count <= ev_count;
      endcase
      if (drop)
        overflow <= 1'b1;
      else if (clr_overflow)
        overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_doodlejump_keycode_sched.sv
// Directed bench for doodlejump_keycode_sched (FIFO_DEPTH=4, REPEAT_DELAY=8, REPEAT_PERIOD=4).
module tb_doodlejump_keycode_sched;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] keycode_in;
  logic       ev_valid, ev_ready;
  logic [7:0] ev_code;
  logic [1:0] ev_type;
  logic [2:0] ev_count;
  logic [7:0] held_code;
  logic       overflow, clr_overflow;

  int n_chk = 0;
  int n_err = 0;

  doodlejump_keycode_sched #(
    .KC_W(8), .FIFO_DEPTH(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .keycode_in(keycode_in),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_type(ev_type),
    .ev_count(ev_count), .held_code(held_code), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit rep_en;
`ifdef KEYSCHED_REPEAT_EN
    rep_en = 1'b1;
`else
    rep_en = 1'b0;
`endif
    reset_n = 1'b0; keycode_in = 8'h1A; ev_ready = 1'b0; clr_overflow = 1'b0;

    // 1: reset with a key already down
    step(2);
    chk("rst_valid", ev_valid, 0);
    chk("rst_code", ev_code, 0);
    chk("rst_type", ev_type, 0);
    chk("rst_count", ev_count, 0);
    chk("rst_held", held_code, 0);
    chk("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    step(3);
    chk("t1_valid", ev_valid, 1);
    chk("t1_code", ev_code, 8'h1A);
    chk("t1_type", ev_type, 2'b00);
    chk("t1_held", held_code, 8'h1A);
    step(2);
    chk("t1_count", ev_count, 1);
    ev_ready = 1'b1;
    step(1);
    chk("t1_drain", ev_count, 0);
    keycode_in = 8'h00;
    step(6);
    chk("t1_idle_held", held_code, 0);
    chk("t1_idle_cnt", ev_count, 0);

    // 2: single press, consumer always ready
    keycode_in = 8'h1A;
    step(2);
    chk("t2_lat_valid", ev_valid, 0);
    step(1);
    chk("t2_valid", ev_valid, 1);
    chk("t2_code", ev_code, 8'h1A);
    chk("t2_type", ev_type, 2'b00);
    chk("t2_count", ev_count, 1);
    step(1);
    chk("t2_popped", ev_valid, 0);
    chk("t2_count0", ev_count, 0);

    // 3: key-to-key change gives RELEASE then PRESS on consecutive cycles
    keycode_in = 8'h07;
    step(3);
    chk("t3_rel_valid", ev_valid, 1);
    chk("t3_rel_code", ev_code, 8'h1A);
    chk("t3_rel_type", ev_type, 2'b01);
    step(1);
    chk("t3_prs_code", ev_code, 8'h07);
    chk("t3_prs_type", ev_type, 2'b00);
    chk("t3_prs_count", ev_count, 1);
    step(1);
    chk("t3_count0", ev_count, 0);
    chk("t3_held", held_code, 8'h07);

    // 4: hold 0x1A; REPEATs at +8,+12,+16,+20 from the PRESS push only with the macro
    keycode_in = 8'h00;
    step(6);
    keycode_in = 8'h1A;
    step(3);
    chk("t4_press", {ev_valid, ev_type}, {1'b1, 2'b00});
    for (int k = 1; k <= 21; k++) begin
      bit exp_rep;
      step(1);
      exp_rep = rep_en && (k == 8 || k == 12 || k == 16 || k == 20);
      chk($sformatf("t4_rep_p%0d", k), {ev_valid && ev_type == 2'b10, ev_valid ? ev_code : 8'h00},
          {exp_rep, exp_rep ? 8'h1A : (ev_valid ? ev_code : 8'h00)});
    end
    keycode_in = 8'h00;
    step(8);
    chk("t4_count0", ev_count, 0);
    chk("t4_held0", held_code, 0);

    // 5: overflow with a stalled consumer
    ev_ready = 1'b0;
    keycode_in = 8'h01; step(5);
    keycode_in = 8'h00; step(5);
    keycode_in = 8'h02; step(5);
    keycode_in = 8'h00; step(5);
    keycode_in = 8'h03; step(5);
    chk("t5_count", ev_count, 4);
    chk("t5_ovf", overflow, 1);
    chk("t5_held", held_code, 8'h03);
    chk("t5_head", {ev_code, ev_type}, {8'h01, 2'b00});
    keycode_in = 8'h00;
    step(2);
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
    chk("t5_popush_cnt", ev_count, 4);
    chk("t5_popush_ovf", overflow, 1);
    chk("t5_popush_head", {ev_code, ev_type}, {8'h01, 2'b01});
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    chk("t5_clr", overflow, 0);
    ev_ready = 1'b1;
    step(1);
    chk("t5_e1", {ev_code, ev_type}, {8'h02, 2'b00});
    step(1);
    chk("t5_e2", {ev_code, ev_type}, {8'h02, 2'b01});
    step(1);
    chk("t5_e3", {ev_code, ev_type}, {8'h03, 2'b01});
    step(1);
    chk("t5_empty", ev_count, 0);

    // 6: reset while in REL of 0x1A
    ev_ready = 1'b0;
    keycode_in = 8'h1A; step(5);
    chk("t6_pre_cnt", ev_count, 1);
    keycode_in = 8'h00; step(2);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_cnt", ev_count, 0);
    chk("t6_rst_valid", ev_valid, 0);
    chk("t6_rst_held", held_code, 0);
    keycode_in = 8'h07;
    step(2);
    reset_n = 1'b1;
    step(3);
    chk("t6_prs", {ev_valid, ev_code, ev_type}, {1'b1, 8'h07, 2'b00});
    step(3);
    chk("t6_only", ev_count, 1);
    chk("t6_held", held_code, 8'h07);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
